// File: rtl/calc_pkg.sv
// Shared opcode/state encodings and opcode legality for param_calc.
// CALC_MUL_EN enables the multi-cycle multiply opcode.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_A = 4'd1,
    S_LOAD_B = 4'd2,
    S_EXEC   = 4'd3,
    S_MUL    = 4'd4,
    S_OUT    = 4'd5,
    S_DONE   = 4'd6
  } state_e;

  // Opcode legality depends on whether the multiplier is built in.
  function automatic logic op_legal(input logic [2:0] op);
`ifdef CALC_MUL_EN
    return (op <= OP_MUL);
`else
    return (op <= OP_XOR);
`endif
  endfunction

endpackage

// File: rtl/param_calc_if.sv
// Operation handshake and result bus between board-level driver and param_calc.
interface param_calc_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned OUT_W = 2 * WIDTH;

  logic             GO;
  logic [2:0]       OP;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             doneFlag;
  logic             busy;
  logic             err;
  logic [3:0]       CurrentState;
  logic [OUT_W-1:0] out;

  modport master (
    output GO, OP, in1, in2,
    input  doneFlag, busy, err, CurrentState, out
  );

  modport slave (
    input  GO, OP, in1, in2,
    output doneFlag, busy, err, CurrentState, out
  );
endinterface

// File: rtl/calc_alu.sv
// Combinational single-cycle ALU: ADD/SUB/AND/OR/XOR with an illegal-opcode flag.
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2:0]         op_i,
  output logic [2*WIDTH-1:0] res_o,
  output logic               illegal_o
);
  localparam int unsigned OUT_W = 2 * WIDTH;

  logic [WIDTH:0] sum_c;
  logic [WIDTH:0] diff_c;

  assign sum_c  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_c = {1'b0, a_i} - {1'b0, b_i};

  // Subtraction keeps the borrow as sign and extends it to the full result.
  always_comb begin
    res_o     = '0;
    illegal_o = !op_legal(op_i);
    case (op_i)
      OP_ADD:  res_o = OUT_W'(sum_c);
      OP_SUB:  res_o = {{(OUT_W - WIDTH - 1){diff_c[WIDTH]}}, diff_c};
      OP_AND:  res_o = OUT_W'(a_i & b_i);
      OP_OR:   res_o = OUT_W'(a_i | b_i);
      OP_XOR:  res_o = OUT_W'(a_i ^ b_i);
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/param_calc.sv
// Multi-cycle two-operand calculator: control unit FSM plus datapath registers.
// Define CALC_MUL_EN to build the shift-add multiplier (opcode 101).
module param_calc
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  param_calc_if.slave  bus
);
  localparam int unsigned OUT_W = 2 * WIDTH;

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] ra_q, rb_q;
  logic [2:0]       rop_q;
  logic [OUT_W-1:0] rr_q, out_q;
  logic             err_nx_q, err_q;
  logic [OUT_W-1:0] alu_res;
  logic             alu_ill;

`ifdef CALC_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  logic [OUT_W-1:0] mcand_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_last_c;
  assign mul_last_c = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i       (ra_q),
    .b_i       (rb_q),
    .op_i      (rop_q),
    .res_o     (alu_res),
    .illegal_o (alu_ill)
  );

  // Control unit: state, completion pulse and busy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = (state_q == S_DONE);
    busy_d  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:   if (bus.GO) state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
`ifdef CALC_MUL_EN
      S_LOAD_B: state_d = (bus.OP == OP_MUL) ? S_MUL : S_EXEC;
      S_MUL:    if (mul_last_c) state_d = S_OUT;
`else
      S_LOAD_B: state_d = S_EXEC;
`endif
      S_EXEC:   state_d = S_OUT;
      S_OUT:    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: operand/result registers, multiplier and output latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra_q     <= '0;
      rb_q     <= '0;
      rop_q    <= '0;
      rr_q     <= '0;
      out_q    <= '0;
      err_nx_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef CALC_MUL_EN
      mcand_q  <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_LOAD_A: ra_q <= bus.in1;
        S_LOAD_B: begin
          rb_q  <= bus.in2;
          rop_q <= bus.OP;
          rr_q  <= '0;
`ifdef CALC_MUL_EN
          mcand_q <= OUT_W'(ra_q);
          cnt_q   <= '0;
`endif
        end
        S_EXEC: begin
          rr_q     <= alu_res;
          err_nx_q <= alu_ill;
        end
`ifdef CALC_MUL_EN
        S_MUL: begin
          if (rb_q[0]) rr_q <= rr_q + mcand_q;
          mcand_q <= mcand_q << 1;
          rb_q    <= rb_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (mul_last_c) err_nx_q <= 1'b0;
        end
`endif
        S_OUT: begin
          out_q <= rr_q;
          err_q <= err_nx_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.doneFlag     = done_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
  assign bus.CurrentState = state_q;
  assign bus.out          = out_q;

endmodule

// File: doc/param_calc.md
# param_calc

Parametrised multi-cycle calculator: next generation of the two-operand small calculator, with a separate control-unit/datapath split and a single-entry operation handshake. Operand width is a parameter, and the opcode set is widened to five logic/arithmetic ops plus an optional multi-cycle multiply. Results are widened to 2·WIDTH, and an error flag reports illegal opcodes. It sits directly under the board top, driven by switches/buttons, with outputs to LEDs/seven-segment.

## Interface
- WIDTH, 4: operand width in bits, legal range 2–16.
- OUT_W, 2*WIDTH: result width. Derived; must not be overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- GO  in  1  start request, level-sampled in IDLE only.
- OP  in  3  opcode, sampled with in2.
- in1  in  WIDTH  operand A (unsigned).
- in2  in  WIDTH  operand B (unsigned).
- doneFlag  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- err  out  1  illegal-opcode flag for the current result.
- CurrentState  out  4  FSM state code.
- out  out  OUT_W  registered result.

## Operation
- Opcodes:
  - 000: ADD, zero-extended sum.
  - 001: SUB, in1−in2 computed in WIDTH+1 bits, sign-extended to OUT_W.
  - 010: AND.
  - 011: OR.
  - 100: XOR.
  - 101: MUL, only with the macro enabled.
  - Any other code is illegal. Logic-op results are zero-extended.
- Internal registers: RA (operand A), RB (operand B), ROP (opcode), RR (result, OUT_W).
- FSM states and codes:
  - IDLE (0): GO=1 → LOAD_A.
  - LOAD_A (1): RA←in1 → LOAD_B.
  - LOAD_B (2): RB←in2, ROP←OP. Go to MUL if ROP is MUL and enabled, else EXEC.
  - EXEC (3): RR←alu(RA,RB,ROP), err_next←illegal(ROP) → OUT.
  - MUL (4): unsigned shift-add multiply, one multiplier bit per cycle over WIDTH cycles. On the final cycle RR←product → OUT.
  - OUT (5): out←RR, err←err_next → DONE.
  - DONE (6): doneFlag=1 → IDLE.
- Illegal opcode: RR←0, err=1. The operation still completes through OUT/DONE.
- GO outside IDLE is ignored. GO held high re-triggers from DONE→IDLE→LOAD_A, giving back-to-back operations with one IDLE cycle between them.
- out and err hold their last values until the next OUT state.
- Reset, whether idle or mid-operation: state=IDLE and RA, RB, ROP, RR, out cleared. Outputs go to doneFlag=0, busy=0, err=0, CurrentState=0, out=0. An in-flight result is discarded.

## Timing
- GO sampled high at edge k.
- in1 sampled at edge k+1.
- in2 and OP sampled at edge k+2. They may change freely at all other times.
- Non-MUL:
  - RR written at k+3.
  - out/err valid after k+4.
  - doneFlag high between edges k+5 and k+6.
- MUL: EXEC is replaced by WIDTH MUL cycles.
  - out valid after k+3+WIDTH.
  - doneFlag high between k+4+WIDTH and k+5+WIDTH.
- busy rises after k+1 and falls after the DONE cycle.
- CurrentState is the registered state, with no decode lag.

## Configuration
- CALC_MUL_EN defined:
  - MUL state and shift-add counter (clog2(WIDTH+1) bits) are compiled in.
  - Opcode 101 is legal.
- CALC_MUL_EN undefined:
  - No MUL state or multiplier logic is present.
  - Opcode 101 is illegal: it takes the EXEC path with err=1 and out=0.
  - State code 4 is unreachable.

## Structure
- Package calc_pkg holds:
  - Opcode constants (OP_ADD…OP_MUL).
  - State constants (S_IDLE…S_DONE, 4-bit).
  - Legal-opcode check function.
- The control unit (FSM, counter, busy/doneFlag) and the datapath (RA/RB/RR, out) are kept as separate logic sections inside param_calc.
- One sub-module, calc_alu: combinational, parametrised by WIDTH, covering ADD/SUB/AND/OR/XOR and the illegal flag. The multiplier stays in param_calc because it is sequential.

## Test plan
- WIDTH=4, in1=9, in2=8, OP=000, GO pulse → out=8'h11, err=0, doneFlag pulse at k+5, CurrentState sequence 0,1,2,3,5,6,0.
- WIDTH=4, in1=3, in2=5, OP=001 → out=8'hFE. Then in1=5, in2=3 → out=8'h02.
- CALC_MUL_EN, WIDTH=4, in1=15, in2=15, OP=101 → out=8'hE1, doneFlag at k+8. Without the macro → out=0, err=1, doneFlag at k+5.
- OP=111 with any operands → out=0, err=1. A following legal ADD 1+1 → out=2, err=0.
- GO re-pulsed during LOAD_B and during MUL → ignored, exactly one doneFlag per accepted start. GO held high → repeated operations spaced 7 cycles apart (non-MUL).
- rst asserted during EXEC, or during MUL at cycle 2 → all outputs 0 immediately (asynchronous). After release with GO low → stays in IDLE, no doneFlag.
